// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM with a completion handshake.
// A grant runs IDLE -> ACCESS -> DONE; an access that outlasts TIMEOUT cycles is aborted and flagged.
module ram_arbiter #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned AW      = 9
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [31:0]   a_wdata,
    output logic [31:0]   a_rdata,
    output logic          a_ack,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [31:0]   b_wdata,
    output logic [31:0]   b_rdata,
    output logic          b_ack,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_address,
    inout  wire  [31:0]   mem_data,
    input  logic          mem_finished,
    output logic          err,
    output logic          err_port
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t          state_q;
    logic            port_q;
    logic            last_grant_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   a_rdata_q;
    logic [DW-1:0]   b_rdata_q;
    logic            a_ack_q;
    logic            b_ack_q;
    logic            mem_read_q;
    logic            mem_write_q;
    logic            err_q;
    logic            err_port_q;
    logic [CW-1:0]   cnt_q;

    logic            grant_b_c;
    logic            sel_we_c;
    logic [AW-1:0]   sel_addr_c;
    logic [DW-1:0]   sel_wdata_c;

    // Round-robin pick: on a tie the port not granted last wins.
    always_comb begin
        grant_b_c = b_req;
        if (a_req && b_req) begin
            grant_b_c = ~last_grant_q;
        end
        sel_we_c    = grant_b_c ? b_we    : a_we;
        sel_addr_c  = grant_b_c ? b_addr  : a_addr;
        sel_wdata_c = grant_b_c ? b_wdata : a_wdata;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q      <= IDLE;
            port_q       <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            err_q        <= 1'b0;
            err_port_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (a_req || b_req) begin
                        state_q      <= ACCESS;
                        port_q       <= grant_b_c;
                        last_grant_q <= grant_b_c;
                        we_q         <= sel_we_c;
                        addr_q       <= sel_addr_c;
                        wdata_q      <= sel_wdata_c;
                        mem_read_q   <= ~sel_we_c;
                        mem_write_q  <= sel_we_c;
                        cnt_q        <= '0;
                    end
                end
                ACCESS: begin
                    if (mem_finished) begin
                        state_q     <= DONE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (!we_q) begin
                            if (port_q) b_rdata_q <= mem_data;
                            else        a_rdata_q <= mem_data;
                        end
                        if (port_q) b_ack_q <= 1'b1;
                        else        a_ack_q <= 1'b1;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        // Abort silently: no ack, sticky error naming the stalled port.
                        state_q     <= IDLE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        err_q       <= 1'b1;
                        err_port_q  <= port_q;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_data    = mem_write_q ? wdata_q : {DW{1'bz}};
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = addr_q;
    assign a_rdata     = a_rdata_q;
    assign b_rdata     = b_rdata_q;
    assign a_ack       = a_ack_q;
    assign b_ack       = b_ack_q;
    assign err         = err_q;
    assign err_port    = err_port_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a 512-word RAM model with programmable completion delay.
module tb_ram_arbiter;

    localparam int unsigned AW = 9;
    localparam logic [31:0] IDLE_PAT = 32'hA5A5_5A5A;

    logic          clock = 1'b0;
    logic          clear = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [31:0]   a_wdata = '0, b_wdata = '0;
    logic [31:0]   a_rdata, b_rdata;
    logic          a_ack, b_ack, mem_read, mem_write, mem_finished, err, err_port;
    logic [AW-1:0] mem_address;
    wire  [31:0]   mem_data;

    logic [31:0]   ram [0:511];
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = '0;
    int            acc_cnt = 0;
    int            fin_delay = 0;
    int            errors = 0;
    int            checks = 0;
    int            overlap = 0;
    int            bus_bad = 0;

    ram_arbiter #(.TIMEOUT(15), .AW(AW)) dut (
        .clock(clock), .clear(clear),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_data(mem_data), .mem_finished(mem_finished),
        .err(err), .err_port(err_port)
    );

    always #5 clock = ~clock;

    // RAM model: drives read data during reads, a marker pattern when idle, floats during writes.
    assign mem_data = (mem_read || !mem_write) ? (mem_read ? ram[mem_address] : IDLE_PAT) : 32'bz;
    assign mem_finished = (mem_read || mem_write) && (acc_cnt >= fin_delay);

    always @(posedge clock) begin
        acc_cnt <= (mem_read || mem_write) ? acc_cnt + 1 : 0;
        if (load_en) ram[load_addr] <= load_data;
        else if (mem_write && mem_finished) ram[mem_address] <= mem_data;
    end

    always @(negedge clock) begin
        if (a_ack && b_ack) overlap++;
        if (!mem_read && !mem_write && mem_data !== IDLE_PAT) bus_bad++;
    end

    task automatic preload(input logic [AW-1:0] addr, input logic [31:0] data);
        @(negedge clock);
        load_en = 1'b1; load_addr = addr; load_data = data;
        @(negedge clock);
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        preload(9'd5, 32'hDEAD_BEEF);
        preload(9'd1, 32'h1111_1111);
        preload(9'd2, 32'h2222_2222);
        preload(9'd3, 32'h3333_3333);
        preload(9'd7, 32'h7777_7777);
        preload(9'd511, 32'h0);
        @(negedge clock);
        checks++; if ({mem_read, mem_write, a_ack, b_ack, err, err_port} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 000000", {mem_read, mem_write, a_ack, b_ack, err, err_port}); end
        checks++; if (mem_address !== 9'd0) begin
            errors++; $display("FAIL reset_addr: got %0h want 0", mem_address); end
        checks++; if ({a_rdata, b_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h want 0", {a_rdata, b_rdata}); end
        checks++; if (mem_data !== IDLE_PAT) begin
            errors++; $display("FAIL reset_bus: got %h want %h", mem_data, IDLE_PAT); end
        clear = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_read();
        fin_delay = 0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'd5;
        @(negedge clock);
        checks++; if ({mem_read, mem_write, a_ack} !== 3'b100) begin
            errors++; $display("FAIL read_strobe: got %b want 100", {mem_read, mem_write, a_ack}); end
        checks++; if (mem_address !== 9'd5) begin
            errors++; $display("FAIL read_addr: got %0h want 5", mem_address); end
        @(negedge clock);
        checks++; if ({a_ack, b_ack} !== 2'b10) begin
            errors++; $display("FAIL read_ack_latency: got %b want 10", {a_ack, b_ack}); end
        checks++; if (a_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL read_data: got %h want deadbeef", a_rdata); end
        checks++; if (b_rdata !== 32'h0) begin
            errors++; $display("FAIL read_other_rdata: got %h want 0", b_rdata); end
        a_req = 1'b0;
        @(negedge clock);
        checks++; if ({a_ack, mem_read} !== 2'b00 || a_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL read_after: got ack/rd %b data %h want 00 deadbeef", {a_ack, mem_read}, a_rdata); end
    endtask

    task automatic test_single_write();
        fin_delay = 0;
        b_req = 1'b1; b_we = 1'b1; b_addr = 9'h1FF; b_wdata = 32'h1234_5678;
        @(negedge clock);
        checks++; if ({mem_read, mem_write} !== 2'b01 || mem_address !== 9'h1FF) begin
            errors++; $display("FAIL write_strobe: got %b addr %0h want 01 1ff", {mem_read, mem_write}, mem_address); end
        checks++; if (mem_data !== 32'h1234_5678) begin
            errors++; $display("FAIL write_bus: got %h want 12345678", mem_data); end
        @(negedge clock);
        checks++; if ({a_ack, b_ack} !== 2'b01) begin
            errors++; $display("FAIL write_ack: got %b want 01", {a_ack, b_ack}); end
        checks++; if (ram[511] !== 32'h1234_5678) begin
            errors++; $display("FAIL write_ram: got %h want 12345678", ram[511]); end
        checks++; if (b_rdata !== 32'h0 || a_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL write_rdata_kept: got %h %h want deadbeef 0", a_rdata, b_rdata); end
        b_req = 1'b0; b_we = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_slow_boundary();
        int acc = 0, acks = 0, addr_bad = 0;
        fin_delay = 14;
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'd7;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (i == 3) begin a_addr = 9'd8; a_we = 1'b1; end
            if (mem_read) begin acc++; if (mem_address !== 9'd7) addr_bad++; end
            if (mem_write) addr_bad++;
            if (a_ack) begin acks++; break; end
        end
        a_req = 1'b0; a_we = 1'b0;
        checks++; if (acks !== 1 || acc !== 15) begin
            errors++; $display("FAIL slow_last_cycle: got acks %0d access %0d want 1 15", acks, acc); end
        checks++; if (addr_bad !== 0) begin
            errors++; $display("FAIL slow_stable: got %0d unstable cycles want 0", addr_bad); end
        checks++; if (a_rdata !== 32'h7777_7777 || err !== 1'b0) begin
            errors++; $display("FAIL slow_data: got %h err %b want 77777777 0", a_rdata, err); end
        @(negedge clock);
        fin_delay = 0;
    endtask

    task automatic test_contention();
        int n = 0, ovl = 0;
        logic [3:0] seq = 4'b0;
        fin_delay = 0;
        clear = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 9'd2;
        @(negedge clock);
        clear = 1'b1;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clock);
            if (a_ack && b_ack) ovl++;
            if (a_ack || b_ack) begin seq = {seq[2:0], b_ack}; n++; end
            if (n == 4) begin a_req = 1'b0; b_req = 1'b0; end
        end
        a_req = 1'b0; b_req = 1'b0;
        checks++; if (n !== 4 || seq !== 4'b0101) begin
            errors++; $display("FAIL contention_order: got %0d acks order %b want 4 0101", n, seq); end
        checks++; if (ovl !== 0) begin
            errors++; $display("FAIL contention_overlap: got %0d want 0", ovl); end
        checks++; if (a_rdata !== 32'h1111_1111 || b_rdata !== 32'h2222_2222) begin
            errors++; $display("FAIL contention_data: got %h %h want 11111111 22222222", a_rdata, b_rdata); end
        @(negedge clock);
    endtask

    task automatic test_timeout();
        int acc = 0, backs = 0;
        fin_delay = 100;
        b_req = 1'b1; b_we = 1'b0; b_addr = 9'd3;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (mem_read) acc++;
            if (b_ack) backs++;
            if (acc > 0 && !mem_read) break;
        end
        b_req = 1'b0;
        checks++; if (acc !== 15 || backs !== 0) begin
            errors++; $display("FAIL timeout_len: got access %0d acks %0d want 15 0", acc, backs); end
        checks++; if ({err, err_port} !== 2'b11) begin
            errors++; $display("FAIL timeout_err: got %b want 11", {err, err_port}); end
        @(negedge clock);
        checks++; if ({b_ack, mem_read, mem_write} !== 3'b000 || b_rdata !== 32'h2222_2222) begin
            errors++; $display("FAIL timeout_idle: got %b %h want 000 22222222", {b_ack, mem_read, mem_write}, b_rdata); end
        fin_delay = 0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'd5;
        @(negedge clock);
        @(negedge clock);
        checks++; if (a_ack !== 1'b1 || a_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL timeout_then_read: got ack %b data %h want 1 deadbeef", a_ack, a_rdata); end
        checks++; if ({err, err_port} !== 2'b11) begin
            errors++; $display("FAIL timeout_sticky: got %b want 11", {err, err_port}); end
        a_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid_access();
        int acks = 0, busy = 0;
        fin_delay = 100;
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'd3;
        @(negedge clock);
        @(negedge clock);
        checks++; if (mem_read !== 1'b1) begin
            errors++; $display("FAIL midreset_pre: got %b want 1", mem_read); end
        #2 clear = 1'b0;
        #1;
        checks++; if ({mem_read, mem_write, a_ack, b_ack, err, err_port} !== 6'b0) begin
            errors++; $display("FAIL midreset_async: got %b want 000000", {mem_read, mem_write, a_ack, b_ack, err, err_port}); end
        checks++; if ({a_rdata, b_rdata} !== 64'h0 || mem_address !== 9'd0) begin
            errors++; $display("FAIL midreset_regs: got %h addr %0h want 0 0", {a_rdata, b_rdata}, mem_address); end
        a_req = 1'b0;
        fin_delay = 0;
        @(negedge clock);
        clear = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (a_ack || b_ack) acks++;
            if (mem_read || mem_write) busy++;
        end
        checks++; if (acks !== 0 || busy !== 0) begin
            errors++; $display("FAIL midreset_release: got acks %0d busy %0d want 0 0", acks, busy); end
    endtask

    task automatic test_back_to_back();
        int acks = 0, post = 0, backs = 0;
        fin_delay = 0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'd3;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (a_ack) acks++;
            if (b_ack) backs++;
            if (acks >= 1) post++;
            if (post == 3) a_req = 1'b0;
        end
        a_req = 1'b0;
        checks++; if (acks !== 2 || backs !== 0) begin
            errors++; $display("FAIL back_to_back: got a acks %0d b acks %0d want 2 0", acks, backs); end
        checks++; if (a_rdata !== 32'h3333_3333) begin
            errors++; $display("FAIL back_to_back_data: got %h want 33333333", a_rdata); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_slow_boundary();
        test_contention();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        checks++; if (overlap !== 0) begin
            errors++; $display("FAIL ack_overlap: got %0d want 0", overlap); end
        checks++; if (bus_bad !== 0) begin
            errors++; $display("FAIL bus_undriven: got %0d bad cycles want 0", bus_bad); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
